jtag_uart_bridge: RTL and testbench

System-clock side of the LM32 JTAG debug UART. Sits directly downstream of the JTAGB primitive and consumes its JTCK/JTDI/JSHIFT/JUPDATE/JCE1 outputs. It implements a 10-bit user data register, oversampled in the `sys_clk` domain, and drives JTDO1 back to the primitive. Host-written bytes land in a small RX FIFO read by the CPU. One CPU-written byte is held for the host to collect.

---
 rtl/jtag_uart_bridge.sv | 170 +++++++++++++++++
 tb/tb_jtag_uart_bridge.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_uart_bridge.sv
// System-clock half of the JTAG debug UART: oversamples the JTAGB user-register
// signals, runs the 10-bit data register, and buffers bytes in each direction.
module jtag_uart_bridge #(
   parameter int RX_DEPTH_LOG2 = 2
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       jtck,
   input  logic       jtdi,
   input  logic       jshift,
   input  logic       jupdate,
   input  logic       jce1,
   output logic       jtdo1,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ack,
   input  logic [7:0] tx_data,
   input  logic       tx_we,
   output logic       tx_busy,
   output logic       rx_overrun
);

   localparam int DEPTH = 1 << RX_DEPTH_LOG2;
   localparam logic [RX_DEPTH_LOG2:0] FULL_COUNT = (RX_DEPTH_LOG2 + 1)'(DEPTH);

   logic [4:0] sync_m;
   logic [4:0] sync_s;
   logic       jtck_s;
   logic       jtdi_s;
   logic       jshift_s;
   logic       jupdate_s;
   logic       jce1_s;
   logic       jtck_d;
   logic       jupdate_d;
   logic       tck_rise;
   logic       upd_rise;

   logic [9:0] sr;
   logic       dr_sel;
   logic [7:0] tx_hold;
   logic       capture;
   logic       shift;
   logic       host_wr;
   logic       host_ack;

   logic [7:0]               mem [DEPTH];
   logic [RX_DEPTH_LOG2-1:0] wr_ptr;
   logic [RX_DEPTH_LOG2-1:0] rd_ptr;
   logic [RX_DEPTH_LOG2:0]   count;
   logic                     rx_full;
   logic                     push;
   logic                     pop;
   logic                     overrun_set;

   // Two-flop synchronizers for all JTAGB signals, plus one delay flop on the
   // two strobes whose rising edges we act on.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         sync_m    <= '0;
         sync_s    <= '0;
         jtck_d    <= 1'b0;
         jupdate_d <= 1'b0;
      end else begin
         sync_m    <= {jtck, jtdi, jshift, jupdate, jce1};
         sync_s    <= sync_m;
         jtck_d    <= jtck_s;
         jupdate_d <= jupdate_s;
      end
   end

   assign jtck_s    = sync_s[4];
   assign jtdi_s    = sync_s[3];
   assign jshift_s  = sync_s[2];
   assign jupdate_s = sync_s[1];
   assign jce1_s    = sync_s[0];

   assign tck_rise = jtck_s & ~jtck_d;
   assign upd_rise = jupdate_s & ~jupdate_d;
   assign capture  = tck_rise & jce1_s & ~jshift_s;
   assign shift    = tck_rise & jce1_s & jshift_s;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         sr    <= '0;
         jtdo1 <= 1'b0;
      end else begin
         jtdo1 <= sr[0];
         if (capture) begin
            sr <= {rx_full, tx_busy, tx_hold};
         end else if (shift) begin
            sr <= {jtdi_s, sr[9:1]};
         end
      end
   end

   // dr_sel guards the update decode so updates of other IRs, or an update
   // arriving after a reset with no fresh capture, are ignored.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         dr_sel <= 1'b0;
      end else if (capture) begin
         dr_sel <= 1'b1;
      end else if (upd_rise) begin
         dr_sel <= 1'b0;
      end
   end

   assign host_wr  = upd_rise & dr_sel & sr[9];
   assign host_ack = upd_rise & dr_sel & sr[8];

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         tx_hold <= '0;
         tx_busy <= 1'b0;
      end else begin
         if (tx_we && !tx_busy) begin
            tx_hold <= tx_data;
         end
         if (host_ack) begin
            tx_busy <= 1'b0;
         end else if (tx_we) begin
            tx_busy <= 1'b1;
         end
      end
   end

   // A same-cycle pop frees the slot the push lands in, so a full FIFO only
   // overruns when nothing is leaving.
   assign rx_full     = (count == FULL_COUNT);
   assign rx_valid    = (count != '0);
   assign pop         = rx_ack & rx_valid;
   assign push        = host_wr & (~rx_full | pop);
   assign overrun_set = host_wr & rx_full & ~pop;
   assign rx_data     = mem[rd_ptr];

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= sr[7:0];
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         rx_overrun <= 1'b0;
      end else if (overrun_set) begin
         rx_overrun <= 1'b1;
      end else if (rx_ack) begin
         rx_overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_jtag_uart_bridge.sv
// Self-checking bench for jtag_uart_bridge: directed vector table, multi-cycle
// corner cases, then random traffic against a queue-based reference model.
module tb_jtag_uart_bridge;

   logic       sys_clk;
   logic       sys_rst;
   logic       jtck;
   logic       jtdi;
   logic       jshift;
   logic       jupdate;
   logic       jce1;
   logic       jtdo1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ack;
   logic [7:0] tx_data;
   logic       tx_we;
   logic       tx_busy;
   logic       rx_overrun;

   int nChecks = 0;
   int nFails  = 0;

   jtag_uart_bridge #(.RX_DEPTH_LOG2(2)) dut (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .jtck       (jtck),
      .jtdi       (jtdi),
      .jshift     (jshift),
      .jupdate    (jupdate),
      .jce1       (jce1),
      .jtdo1      (jtdo1),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ack     (rx_ack),
      .tx_data    (tx_data),
      .tx_we      (tx_we),
      .tx_busy    (tx_busy),
      .rx_overrun (rx_overrun)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   initial begin
      #500us;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   typedef struct {
      logic       we;
      logic [7:0] txd;
      logic [9:0] din;
      logic       ack;
      logic [9:0] expCap;
      logic       expValid;
      logic [7:0] expData;
      logic       expBusy;
      logic       expOvr;
   } vec_t;

   vec_t vecs[9];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // JTCK is ten sys_clk periods long, driven on sys_clk falling edges.
   task automatic jtckPulse();
      jtck = 1'b1;
      repeat (5) @(negedge sys_clk);
      jtck = 1'b0;
      repeat (5) @(negedge sys_clk);
   endtask

   task automatic updatePulse();
      jupdate = 1'b1;
      repeat (5) @(negedge sys_clk);
      jupdate = 1'b0;
      repeat (5) @(negedge sys_clk);
   endtask

   task automatic scanDr(input logic [9:0] din, input bit doCapture, input bit doUpdate,
                         output logic [9:0] cap);
      cap = '0;
      @(negedge sys_clk);
      jce1   = 1'b1;
      jshift = 1'b0;
      repeat (2) @(negedge sys_clk);
      if (doCapture) jtckPulse();
      jshift = 1'b1;
      repeat (2) @(negedge sys_clk);
      for (int i = 0; i < 10; i++) begin
         cap[i] = jtdo1;
         jtdi   = din[i];
         jtckPulse();
      end
      jshift = 1'b0;
      jce1   = 1'b0;
      jtdi   = 1'b0;
      repeat (2) @(negedge sys_clk);
      if (doUpdate) updatePulse();
   endtask

   task automatic cpuWrite(input logic [7:0] d);
      @(negedge sys_clk);
      tx_data = d;
      tx_we   = 1'b1;
      @(negedge sys_clk);
      tx_we   = 1'b0;
   endtask

   task automatic cpuAck();
      @(negedge sys_clk);
      rx_ack = 1'b1;
      @(negedge sys_clk);
      rx_ack = 1'b0;
   endtask

   task automatic resetDut();
      @(negedge sys_clk);
      sys_rst = 1'b1;
      jtck = 1'b0; jtdi = 1'b0; jshift = 1'b0; jupdate = 1'b0; jce1 = 1'b0;
      rx_ack = 1'b0; tx_we = 1'b0; tx_data = '0;
      repeat (2) @(negedge sys_clk);
      sys_rst = 1'b0;
      repeat (2) @(negedge sys_clk);
   endtask

   task automatic applyStimulus(input int idx, input vec_t v);
      logic [9:0] cap;
      if (v.we) cpuWrite(v.txd);
      scanDr(v.din, 1'b1, 1'b1, cap);
      checkOutput($sformatf("vec%0d_cap", idx), 32'(cap), 32'(v.expCap));
      checkOutput($sformatf("vec%0d_valid", idx), 32'(rx_valid), 32'(v.expValid));
      if (v.expValid) checkOutput($sformatf("vec%0d_data", idx), 32'(rx_data), 32'(v.expData));
      checkOutput($sformatf("vec%0d_busy", idx), 32'(tx_busy), 32'(v.expBusy));
      checkOutput($sformatf("vec%0d_ovr", idx), 32'(rx_overrun), 32'(v.expOvr));
      if (v.ack) cpuAck();
   endtask

   logic [7:0] mq[$];
   bit         mBusy;
   logic [7:0] mHold;
   bit         mOvr;
   int         op;
   logic [1:0] cmd;
   logic [7:0] d;
   logic [9:0] cap;
   logic [9:0] expCap;
   logic [7:0] expOrder[4];

   initial begin
      //            we    txd    din      ack   cap      valid data   busy  ovr
      vecs[0] = '{1'b1, 8'h5A, 10'h241, 1'b0, 10'h15A, 1'b1, 8'h41, 1'b1, 1'b0};
      vecs[1] = '{1'b0, 8'h00, 10'h100, 1'b1, 10'h15A, 1'b1, 8'h41, 1'b0, 1'b0};
      vecs[2] = '{1'b0, 8'h00, 10'h201, 1'b0, 10'h05A, 1'b1, 8'h01, 1'b0, 1'b0};
      vecs[3] = '{1'b0, 8'h00, 10'h202, 1'b0, 10'h05A, 1'b1, 8'h01, 1'b0, 1'b0};
      vecs[4] = '{1'b0, 8'h00, 10'h203, 1'b0, 10'h05A, 1'b1, 8'h01, 1'b0, 1'b0};
      vecs[5] = '{1'b0, 8'h00, 10'h204, 1'b0, 10'h05A, 1'b1, 8'h01, 1'b0, 1'b0};
      vecs[6] = '{1'b0, 8'h00, 10'h205, 1'b1, 10'h25A, 1'b1, 8'h01, 1'b0, 1'b1};
      vecs[7] = '{1'b1, 8'h33, 10'h000, 1'b1, 10'h133, 1'b1, 8'h02, 1'b1, 1'b0};
      vecs[8] = '{1'b1, 8'h44, 10'h301, 1'b0, 10'h133, 1'b1, 8'h03, 1'b0, 1'b0};

      sys_rst = 1'b1;
      jtck = 1'b0; jtdi = 1'b0; jshift = 1'b0; jupdate = 1'b0; jce1 = 1'b0;
      rx_ack = 1'b0; tx_we = 1'b0; tx_data = '0;
      repeat (3) @(negedge sys_clk);
      checkOutput("rst_jtdo1", 32'(jtdo1), 0);
      checkOutput("rst_valid", 32'(rx_valid), 0);
      checkOutput("rst_data", 32'(rx_data), 0);
      checkOutput("rst_busy", 32'(tx_busy), 0);
      checkOutput("rst_ovr", 32'(rx_overrun), 0);
      sys_rst = 1'b0;
      repeat (2) @(negedge sys_clk);

      for (int i = 0; i < 9; i++) applyStimulus(i, vecs[i]);

      // Asynchronous reset in the middle of a shift, then a shift-only scan
      // with no fresh capture must not be decoded.
      cpuWrite(8'h77);
      @(negedge sys_clk);
      jce1 = 1'b1; jshift = 1'b0;
      repeat (2) @(negedge sys_clk);
      jtckPulse();
      jshift = 1'b1;
      for (int i = 0; i < 3; i++) begin
         jtdi = 1'b1;
         jtckPulse();
      end
      @(posedge sys_clk);
      #3 sys_rst = 1'b1;
      #1;
      checkOutput("midrst_jtdo1", 32'(jtdo1), 0);
      checkOutput("midrst_valid", 32'(rx_valid), 0);
      checkOutput("midrst_data", 32'(rx_data), 0);
      checkOutput("midrst_busy", 32'(tx_busy), 0);
      checkOutput("midrst_ovr", 32'(rx_overrun), 0);
      @(negedge sys_clk);
      jtck = 1'b0; jtdi = 1'b0; jshift = 1'b0; jce1 = 1'b0;
      repeat (2) @(negedge sys_clk);
      sys_rst = 1'b0;
      repeat (2) @(negedge sys_clk);
      scanDr(10'h3AB, 1'b0, 1'b1, cap);
      checkOutput("nocap_upd_valid", 32'(rx_valid), 0);
      checkOutput("nocap_upd_busy", 32'(tx_busy), 0);

      // Exact update latency: rx_valid rises on the third sys_clk edge after jupdate.
      scanDr(10'h241, 1'b1, 1'b0, cap);
      @(negedge sys_clk);
      jupdate = 1'b1;
      repeat (2) @(posedge sys_clk);
      #1 checkOutput("upd_lat_early", 32'(rx_valid), 0);
      @(posedge sys_clk);
      #1 checkOutput("upd_lat_valid", 32'(rx_valid), 1);
      checkOutput("upd_lat_data", 32'(rx_data), 32'h41);
      repeat (4) @(negedge sys_clk);
      jupdate = 1'b0;
      repeat (5) @(negedge sys_clk);
      cpuAck();
      checkOutput("ack_empty", 32'(rx_valid), 0);

      // Push and pop colliding on a full FIFO.
      resetDut();
      for (int i = 0; i < 4; i++) scanDr({2'b10, 8'(8'h11 + i)}, 1'b1, 1'b1, cap);
      scanDr(10'h277, 1'b1, 1'b0, cap);
      checkOutput("full_cap_bit9", 32'(cap[9]), 1);
      @(negedge sys_clk);
      jupdate = 1'b1;
      repeat (2) @(posedge sys_clk);
      @(negedge sys_clk);
      rx_ack = 1'b1;
      @(negedge sys_clk);
      rx_ack = 1'b0;
      checkOutput("coll_ovr", 32'(rx_overrun), 0);
      repeat (3) @(negedge sys_clk);
      jupdate = 1'b0;
      repeat (5) @(negedge sys_clk);
      expOrder = '{8'h12, 8'h13, 8'h14, 8'h77};
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("coll_valid%0d", i), 32'(rx_valid), 1);
         checkOutput($sformatf("coll_data%0d", i), 32'(rx_data), 32'(expOrder[i]));
         cpuAck();
      end
      checkOutput("coll_drained", 32'(rx_valid), 0);

      // tx_we colliding with a host ack is ignored.
      cpuWrite(8'h5A);
      checkOutput("txc_busy_set", 32'(tx_busy), 1);
      scanDr(10'h100, 1'b1, 1'b0, cap);
      @(negedge sys_clk);
      jupdate = 1'b1;
      repeat (2) @(posedge sys_clk);
      @(negedge sys_clk);
      tx_data = 8'hC3;
      tx_we   = 1'b1;
      @(negedge sys_clk);
      tx_we   = 1'b0;
      checkOutput("txc_busy_clr", 32'(tx_busy), 0);
      repeat (3) @(negedge sys_clk);
      jupdate = 1'b0;
      repeat (5) @(negedge sys_clk);
      scanDr(10'h000, 1'b1, 1'b1, cap);
      checkOutput("txc_hold", 32'(cap[8:0]), 32'h05A);

      // Foreign updates after a completed write change nothing.
      scanDr(10'h266, 1'b1, 1'b1, cap);
      updatePulse();
      updatePulse();
      checkOutput("foreign_data", 32'(rx_data), 32'h66);
      cpuAck();
      checkOutput("foreign_valid", 32'(rx_valid), 0);
      checkOutput("foreign_busy", 32'(tx_busy), 0);

      // Pointer wrap-around.
      for (int i = 0; i < 10; i++) begin
         scanDr({2'b10, 8'(8'hA0 + i)}, 1'b1, 1'b1, cap);
         checkOutput($sformatf("wrap_data%0d", i), 32'(rx_data), 32'(8'hA0 + i));
         cpuAck();
      end
      checkOutput("wrap_empty", 32'(rx_valid), 0);

      // Random traffic against a queue model.
      resetDut();
      mq.delete();
      mBusy = 1'b0;
      mHold = '0;
      mOvr  = 1'b0;
      for (int n = 0; n < 60; n++) begin
         op = $urandom_range(0, 3);
         d  = 8'($urandom);
         if (op == 0) begin
            cpuWrite(d);
            if (!mBusy) begin
               mHold = d;
               mBusy = 1'b1;
            end
         end else if (op == 3) begin
            cpuAck();
            if (mq.size() > 0) void'(mq.pop_front());
            mOvr = 1'b0;
         end else begin
            cmd    = 2'($urandom_range(0, 3));
            expCap = {(mq.size() == 4), mBusy, mHold};
            scanDr({cmd, d}, 1'b1, 1'b1, cap);
            checkOutput("rand_cap", 32'(cap), 32'(expCap));
            if (cmd[1]) begin
               if (mq.size() < 4) mq.push_back(d);
               else mOvr = 1'b1;
            end
            if (cmd[0]) mBusy = 1'b0;
         end
         checkOutput("rand_valid", 32'(rx_valid), 32'(mq.size() > 0));
         if (mq.size() > 0) checkOutput("rand_data", 32'(rx_data), 32'(mq[0]));
         checkOutput("rand_busy", 32'(tx_busy), 32'(mBusy));
         checkOutput("rand_ovr", 32'(rx_overrun), 32'(mOvr));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
